sector_seek_ctrl: RTL and testbench

Sequences one sector access on the floppy read path. Accepts a (track, side, sector) request and watches the parsed ID-header stream from `sector_header`. It counts index pulses to bound the search, then opens a data window for the downstream data-field reader. It reports one completion status per request: OK, not found, wrong track, data timeout or aborted.

---
 rtl/sector_seek_ctrl_pkg.sv | 24 ++
 rtl/sector_seek_ctrl_if.sv | 43 ++++
 rtl/sector_seek_ctrl_timeout_counter.sv | 27 ++
 rtl/sector_seek_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sector_seek_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sector_seek_ctrl_pkg.sv
// Shared definitions for the floppy sector seek controller: ID field width,
// completion status codes and FSM state encoding.
package sector_seek_ctrl_pkg;

    localparam int ID_W = 8;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_NOT_FOUND    = 3'd1;
    localparam logic [2:0] ST_WRONG_TRACK  = 3'd2;
    localparam logic [2:0] ST_DATA_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_ABORTED      = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DATA   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sector_seek_ctrl_if.sv
// Request, header-stream and status bundle between a requester (master) and
// the sector seek controller (slave).
interface sector_seek_ctrl_if;
    import sector_seek_ctrl_pkg::*;

    logic            i_Req;
    logic [ID_W-1:0] i_Track;
    logic [ID_W-1:0] i_Side;
    logic [ID_W-1:0] i_Sector;
    logic            i_Abort;
    logic            i_Index;
    logic            i_HdrValid;
    logic            i_HdrCRCError;
    logic [ID_W-1:0] i_HdrTrack;
    logic [ID_W-1:0] i_HdrSide;
    logic [ID_W-1:0] i_HdrSector;
    logic [ID_W-1:0] i_HdrSize;
    logic            i_DataDone;
    logic            o_Busy;
    logic            o_DataEnable;
    logic [ID_W-1:0] o_SectorSize;
    logic            o_Done;
    logic [2:0]      o_Status;
    logic [3:0]      o_CRCErrCount;
    logic [1:0]      o_State;

    modport master (
        output i_Req, i_Track, i_Side, i_Sector, i_Abort, i_Index,
               i_HdrValid, i_HdrCRCError, i_HdrTrack, i_HdrSide,
               i_HdrSector, i_HdrSize, i_DataDone,
        input  o_Busy, o_DataEnable, o_SectorSize, o_Done, o_Status,
               o_CRCErrCount, o_State
    );

    modport slave (
        input  i_Req, i_Track, i_Side, i_Sector, i_Abort, i_Index,
               i_HdrValid, i_HdrCRCError, i_HdrTrack, i_HdrSide,
               i_HdrSector, i_HdrSize, i_DataDone,
        output o_Busy, o_DataEnable, o_SectorSize, o_Done, o_Status,
               o_CRCErrCount, o_State
    );

endinterface

// File: rtl/sector_seek_ctrl_timeout_counter.sv
// Clear/enable up-counter with a terminal-count flag; clear wins over enable.
module sector_seek_ctrl_timeout_counter #(
    parameter int          W    = 4,
    parameter int unsigned TERM = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == TERM[W-1:0]);

endmodule

// File: rtl/sector_seek_ctrl.sv
// Sequences one sector access: searches the ID-header stream for the target
// sector within a bounded number of revolutions, then opens a data window.
module sector_seek_ctrl
    import sector_seek_ctrl_pkg::*;
#(
    parameter int P_MAX_REVS    = 2,
    parameter int P_DATA_WINDOW = 1024
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    sector_seek_ctrl_if.slave  bus
);

    localparam int WIN_W = $clog2(P_DATA_WINDOW);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] tgt_track;
    logic [ID_W-1:0] tgt_side;
    logic [ID_W-1:0] tgt_sector;
    logic            wt_flag;
    logic [2:0]      status;
    logic [ID_W-1:0] sector_size;
    logic [3:0]      crc_cnt;

    logic            accept;
    logic            rev_en;
    logic            rev_tc;
    logic            win_clr;
    logic            win_en;
    logic            win_tc;
    logic            size_ld;
    logic            wt_set;
    logic            status_ld;
    logic [2:0]      status_nxt;
    logic            hdr_match;
    logic            hdr_wrong_track;

    assign hdr_match = bus.i_HdrValid &&
                       (bus.i_HdrTrack  == tgt_track) &&
                       (bus.i_HdrSide   == tgt_side)  &&
                       (bus.i_HdrSector == tgt_sector);
    assign hdr_wrong_track = bus.i_HdrValid && (bus.i_HdrTrack != tgt_track);

    // Revolution counter flags the pulse that would exhaust the search.
    sector_seek_ctrl_timeout_counter #(
        .W    (4),
        .TERM (P_MAX_REVS - 1)
    ) u_rev_cnt (
        .clk (i_Clk),
        .rst (i_Reset),
        .clr (accept),
        .en  (rev_en),
        .tc  (rev_tc)
    );

    sector_seek_ctrl_timeout_counter #(
        .W    (WIN_W),
        .TERM (P_DATA_WINDOW - 1)
    ) u_win_cnt (
        .clk (i_Clk),
        .rst (i_Reset),
        .clr (win_clr),
        .en  (win_en),
        .tc  (win_tc)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        rev_en     = 1'b0;
        win_clr    = 1'b0;
        win_en     = 1'b0;
        size_ld    = 1'b0;
        wt_set     = 1'b0;
        status_ld  = 1'b0;
        status_nxt = ST_OK;
        case (state)
            S_IDLE: begin
                if (bus.i_Req) begin
                    accept    = 1'b1;
                    state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (bus.i_Abort) begin
                    status_ld  = 1'b1;
                    status_nxt = ST_ABORTED;
                    state_nxt  = S_FINISH;
                end else if (hdr_match) begin
                    size_ld   = 1'b1;
                    win_clr   = 1'b1;
                    state_nxt = S_DATA;
                end else begin
                    wt_set = hdr_wrong_track;
                    if (bus.i_Index) begin
                        rev_en = 1'b1;
                        if (rev_tc) begin
                            // A wrong-track header on the final pulse still counts.
                            status_ld  = 1'b1;
                            status_nxt = (wt_flag || hdr_wrong_track) ? ST_WRONG_TRACK
                                                                      : ST_NOT_FOUND;
                            state_nxt  = S_FINISH;
                        end
                    end
                end
            end
            S_DATA: begin
                win_en = 1'b1;
                if (bus.i_Abort) begin
                    status_ld  = 1'b1;
                    status_nxt = ST_ABORTED;
                    state_nxt  = S_FINISH;
                end else if (bus.i_DataDone) begin
                    status_ld  = 1'b1;
                    status_nxt = ST_OK;
                    state_nxt  = S_FINISH;
                end else if (win_tc) begin
                    status_ld  = 1'b1;
                    status_nxt = ST_DATA_TIMEOUT;
                    state_nxt  = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The target only matters while busy, so it carries no reset.
    always_ff @(posedge i_Clk) begin
        if (accept) begin
            tgt_track  <= bus.i_Track;
            tgt_side   <= bus.i_Side;
            tgt_sector <= bus.i_Sector;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            wt_flag     <= 1'b0;
            status      <= ST_OK;
            sector_size <= '0;
            crc_cnt     <= 4'd0;
        end else if (accept) begin
            wt_flag <= 1'b0;
            status  <= ST_OK;
            crc_cnt <= 4'd0;
        end else begin
            if (wt_set) begin
                wt_flag <= 1'b1;
            end
            if (status_ld) begin
                status <= status_nxt;
            end
            if (size_ld) begin
                sector_size <= bus.i_HdrSize;
            end
            if ((state == S_SEARCH) && bus.i_HdrCRCError) begin
                crc_cnt <= sat_inc4(crc_cnt);
            end
        end
    end

    assign bus.o_Busy        = (state == S_SEARCH) || (state == S_DATA);
    assign bus.o_DataEnable  = (state == S_DATA);
    assign bus.o_Done        = (state == S_FINISH);
    assign bus.o_State       = state;
    assign bus.o_Status      = status;
    assign bus.o_SectorSize  = sector_size;
    assign bus.o_CRCErrCount = crc_cnt;

endmodule

// File: tb/tb_sector_seek_ctrl.sv
// Bench for sector_seek_ctrl: per-request event tables, scored against an
// outcome model that scans the table with the seek rules.
module tb_sector_seek_ctrl;

    localparam int N    = 96;
    localparam int MAXR = 2;
    localparam int WIN  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sector_seek_ctrl_if bus();

    sector_seek_ctrl #(
        .P_MAX_REVS    (MAXR),
        .P_DATA_WINDOW (WIN)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    bit         ev_idx[N], ev_hv[N], ev_crc[N], ev_abort[N], ev_done[N], ev_req[N];
    logic [7:0] ev_ht[N], ev_hs[N], ev_hr[N], ev_hz[N];
    logic [7:0] oth_t, oth_s, oth_r;

    int         vectors = 0;
    int         miscompares = 0;

    int         e_done, e_dstart;
    logic [2:0] e_status;
    logic [3:0] e_crc;
    logic [7:0] e_size;
    logic [7:0] last_size = 8'd0;
    logic [2:0] prev_status = 3'd0;
    logic [3:0] prev_crc = 4'd0;

    task automatic drive_zero();
        bus.i_Req = 1'b0;        bus.i_Abort = 1'b0;      bus.i_Index = 1'b0;
        bus.i_HdrValid = 1'b0;   bus.i_HdrCRCError = 1'b0; bus.i_DataDone = 1'b0;
        bus.i_Track = 8'd0;      bus.i_Side = 8'd0;       bus.i_Sector = 8'd0;
        bus.i_HdrTrack = 8'd0;   bus.i_HdrSide = 8'd0;    bus.i_HdrSector = 8'd0;
        bus.i_HdrSize = 8'd0;
    endtask

    task automatic clear_events();
        for (int k = 0; k < N; k++) begin
            ev_idx[k] = 0; ev_hv[k] = 0; ev_crc[k] = 0; ev_abort[k] = 0;
            ev_done[k] = 0; ev_req[k] = 0;
            ev_ht[k] = 8'd0; ev_hs[k] = 8'd0; ev_hr[k] = 8'd0; ev_hz[k] = 8'd0;
        end
        oth_t = 8'd0; oth_s = 8'd0; oth_r = 8'd0;
    endtask

    task automatic set_hdr(input int k, input logic [7:0] t, s, r, z);
        ev_hv[k] = 1; ev_ht[k] = t; ev_hs[k] = s; ev_hr[k] = r; ev_hz[k] = z;
    endtask

    task automatic drive_ev(input int k);
        bus.i_Index = ev_idx[k];      bus.i_HdrValid = ev_hv[k];
        bus.i_HdrCRCError = ev_crc[k]; bus.i_Abort = ev_abort[k];
        bus.i_DataDone = ev_done[k];  bus.i_Req = ev_req[k];
        bus.i_HdrTrack = ev_ht[k];    bus.i_HdrSide = ev_hs[k];
        bus.i_HdrSector = ev_hr[k];   bus.i_HdrSize = ev_hz[k];
        bus.i_Track = oth_t;          bus.i_Side = oth_s;
        bus.i_Sector = oth_r;
    endtask

    // Outcome of one request; cycle 0 is the first SEARCH cycle.
    task automatic model(input logic [7:0] tt, ts, tr);
        int revs = 0;
        int crc = 0;
        bit wt = 0;
        e_done = -1; e_dstart = -1; e_size = last_size; e_status = 3'd0;
        for (int k = 0; k < N && e_done < 0; k++) begin
            if (e_dstart < 0) begin
                if (ev_crc[k] && crc < 15) crc++;
                if (ev_abort[k]) begin
                    e_done = k + 1; e_status = 3'd4;
                end else if (ev_hv[k] && ev_ht[k] == tt && ev_hs[k] == ts && ev_hr[k] == tr) begin
                    e_dstart = k + 1; e_size = ev_hz[k];
                end else begin
                    if (ev_hv[k] && ev_ht[k] != tt) wt = 1;
                    if (ev_idx[k]) begin
                        revs++;
                        if (revs == MAXR) begin
                            e_done = k + 1; e_status = wt ? 3'd2 : 3'd1;
                        end
                    end
                end
            end else if (k >= e_dstart) begin
                if (ev_abort[k]) begin
                    e_done = k + 1; e_status = 3'd4;
                end else if (ev_done[k]) begin
                    e_done = k + 1; e_status = 3'd0;
                end else if (k - e_dstart == WIN - 1) begin
                    e_done = k + 1; e_status = 3'd3;
                end
            end
        end
        e_crc = 4'(crc);
    endtask

    // Entered #1 after a posedge with the DUT in IDLE; returns likewise.
    task automatic run_req(input logic [7:0] tt, ts, tr);
        logic [1:0] es;
        bit         eb, ed, edn;
        model(tt, ts, tr);
        vectors++;
        if (e_done < 0) begin
            miscompares++;
            $display("FAIL table: request never completes in %0d cycles", N);
            return;
        end
        vectors++;
        if (bus.o_Busy !== 1'b0 || bus.o_Done !== 1'b0 || bus.o_State !== 2'd0 ||
            bus.o_Status !== prev_status || bus.o_CRCErrCount !== prev_crc) begin
            miscompares++;
            $display("FAIL idle_hold: busy=%b done=%b state=%0d status=%0d crc=%0d want 0 0 0 %0d %0d",
                     bus.o_Busy, bus.o_Done, bus.o_State, bus.o_Status, bus.o_CRCErrCount,
                     prev_status, prev_crc);
        end
        drive_zero();
        bus.i_Req = 1'b1; bus.i_Track = tt; bus.i_Side = ts; bus.i_Sector = tr;
        @(posedge clk); #1;
        for (int k = 0; k <= e_done; k++) begin
            if (k < e_done) drive_ev(k);
            else drive_zero();
            @(negedge clk);
            eb  = (k < e_done);
            ed  = (e_dstart >= 0) && (k >= e_dstart) && (k < e_done);
            edn = (k == e_done);
            es  = edn ? 2'd3 : (ed ? 2'd2 : 2'd1);
            vectors++;
            if (bus.o_Busy !== eb || bus.o_DataEnable !== ed || bus.o_Done !== edn ||
                bus.o_State !== es) begin
                miscompares++;
                $display("FAIL cycle%0d busy/de/done/state: got %b%b%b/%0d want %b%b%b/%0d",
                         k, bus.o_Busy, bus.o_DataEnable, bus.o_Done, bus.o_State,
                         eb, ed, edn, es);
            end
            if (k == 0) begin
                vectors++;
                if (bus.o_Status !== 3'd0 || bus.o_CRCErrCount !== 4'd0) begin
                    miscompares++;
                    $display("FAIL accept_clear: status=%0d crc=%0d want 0 0",
                             bus.o_Status, bus.o_CRCErrCount);
                end
            end
            if (edn) begin
                vectors++;
                if (bus.o_Status !== e_status || bus.o_CRCErrCount !== e_crc ||
                    bus.o_SectorSize !== e_size) begin
                    miscompares++;
                    $display("FAIL completion: status=%0d crc=%0d size=%0d want %0d %0d %0d",
                             bus.o_Status, bus.o_CRCErrCount, bus.o_SectorSize,
                             e_status, e_crc, e_size);
                end
            end
            @(posedge clk); #1;
        end
        last_size = e_size; prev_status = e_status; prev_crc = e_crc;
    endtask

    task automatic expect_status(input string name, input logic [2:0] want);
        vectors++;
        if (bus.o_Status !== want) begin
            miscompares++;
            $display("FAIL %s: status=%0d want %0d", name, bus.o_Status, want);
        end
    endtask

    task automatic test_reset();
        drive_zero();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.o_Busy !== 1'b0 || bus.o_DataEnable !== 1'b0 || bus.o_SectorSize !== 8'd0 ||
            bus.o_Done !== 1'b0 || bus.o_Status !== 3'd0 || bus.o_CRCErrCount !== 4'd0 ||
            bus.o_State !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b de=%b size=%0d done=%b status=%0d crc=%0d state=%0d want all 0",
                     bus.o_Busy, bus.o_DataEnable, bus.o_SectorSize, bus.o_Done,
                     bus.o_Status, bus.o_CRCErrCount, bus.o_State);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_match();
        clear_events();
        set_hdr(2, 8'd5, 8'd0, 8'd1, 8'd0);
        set_hdr(5, 8'd5, 8'd0, 8'd3, 8'd2);
        ev_done[16] = 1;
        run_req(8'd5, 8'd0, 8'd3);
        expect_status("basic_ok", 3'd0);
        vectors++;
        if (bus.o_SectorSize !== 8'd2) begin
            miscompares++;
            $display("FAIL basic_size: size=%0d want 2", bus.o_SectorSize);
        end
    endtask

    task automatic test_not_found();
        clear_events();
        for (int r = 1; r <= 8; r++) set_hdr(r * 4, 8'd5, 8'd0, 8'(r), 8'd1);
        ev_idx[10] = 1;
        ev_idx[40] = 1;
        run_req(8'd5, 8'd0, 8'd9);
        expect_status("not_found", 3'd1);
    endtask

    task automatic test_wrong_track();
        clear_events();
        for (int r = 1; r <= 8; r++) set_hdr(r * 3, 8'd4, 8'd0, 8'(r), 8'd1);
        ev_idx[10] = 1;
        ev_idx[30] = 1;
        run_req(8'd5, 8'd0, 8'd3);
        expect_status("wrong_track", 3'd2);
    endtask

    task automatic test_timeout();
        clear_events();
        set_hdr(3, 8'd7, 8'd1, 8'd4, 8'd3);
        ev_idx[8] = 1;
        ev_hv[9] = 0;
        run_req(8'd7, 8'd1, 8'd4);
        expect_status("timeout", 3'd3);
    endtask

    task automatic test_match_on_last_index();
        clear_events();
        ev_idx[5] = 1;
        ev_idx[20] = 1;
        set_hdr(20, 8'd2, 8'd1, 8'd6, 8'd1);
        ev_abort[25] = 1;
        run_req(8'd2, 8'd1, 8'd6);
        expect_status("abort_data", 3'd4);
    endtask

    task automatic test_crc_and_busy_req();
        clear_events();
        for (int k = 0; k < 20; k++) ev_crc[k] = 1;
        oth_t = 8'd1; oth_s = 8'd0; oth_r = 8'd2;
        ev_req[3] = 1;
        ev_req[21] = 1;
        set_hdr(24, 8'd1, 8'd0, 8'd2, 8'd3);
        ev_idx[25] = 1;
        ev_idx[30] = 1;
        run_req(8'd1, 8'd0, 8'd1);
        expect_status("busy_req_ignored", 3'd1);
        vectors++;
        if (bus.o_CRCErrCount !== 4'd15) begin
            miscompares++;
            $display("FAIL crc_saturate: crc=%0d want 15", bus.o_CRCErrCount);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            clear_events();
            ev_abort[i] = 1;
            run_req(8'(i), 8'd0, 8'd1);
            expect_status("b2b_abort", 3'd4);
        end
    endtask

    task automatic test_reset_mid_data();
        bit saw_done = 0;
        drive_zero();
        bus.i_Req = 1'b1; bus.i_Track = 8'd9; bus.i_Side = 8'd1; bus.i_Sector = 8'd5;
        @(posedge clk); #1;
        drive_zero();
        bus.i_HdrValid = 1'b1; bus.i_HdrTrack = 8'd9; bus.i_HdrSide = 8'd1;
        bus.i_HdrSector = 8'd5; bus.i_HdrSize = 8'd3;
        @(posedge clk); #1;
        drive_zero();
        @(posedge clk); #1;
        vectors++;
        if (bus.o_DataEnable !== 1'b1 || bus.o_SectorSize !== 8'd3) begin
            miscompares++;
            $display("FAIL pre_reset_data: de=%b size=%0d want 1 3", bus.o_DataEnable, bus.o_SectorSize);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.o_Done !== 1'b0) saw_done = 1;
            if (k == 0) begin
                vectors++;
                if (bus.o_Busy !== 1'b0 || bus.o_DataEnable !== 1'b0 || bus.o_SectorSize !== 8'd0 ||
                    bus.o_Status !== 3'd0 || bus.o_CRCErrCount !== 4'd0 || bus.o_State !== 2'd0) begin
                    miscompares++;
                    $display("FAIL mid_reset: busy=%b de=%b size=%0d status=%0d crc=%0d state=%0d want all 0",
                             bus.o_Busy, bus.o_DataEnable, bus.o_SectorSize, bus.o_Status,
                             bus.o_CRCErrCount, bus.o_State);
                end
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL mid_reset_done: done pulse seen=1 want 0");
        end
        last_size = 8'd0; prev_status = 3'd0; prev_crc = 4'd0;
    endtask

    task automatic gen_random(input logic [7:0] tt, ts, tr);
        clear_events();
        oth_t = tt; oth_s = ts; oth_r = tr + 8'd1;
        for (int k = 0; k < N; k++) begin
            ev_idx[k]   = ($urandom_range(9, 0) == 0);
            ev_hv[k]    = ($urandom_range(3, 0) == 0);
            ev_crc[k]   = ($urandom_range(5, 0) == 0);
            ev_abort[k] = ($urandom_range(59, 0) == 0);
            ev_done[k]  = ($urandom_range(11, 0) == 0);
            ev_req[k]   = ($urandom_range(14, 0) == 0);
            ev_ht[k] = 8'($urandom); ev_hs[k] = 8'($urandom);
            ev_hr[k] = 8'($urandom); ev_hz[k] = 8'($urandom);
            if (ev_hv[k]) begin
                case ($urandom_range(5, 0))
                    0: begin ev_ht[k] = tt; ev_hs[k] = ts; ev_hr[k] = tr; end
                    1: begin ev_ht[k] = tt; ev_hs[k] = ts; ev_hr[k] = tr + 8'd1; end
                    2: begin ev_ht[k] = tt; ev_hs[k] = ts ^ 8'd1; ev_hr[k] = tr; end
                    3: begin ev_ht[k] = tt ^ 8'($urandom_range(255, 1)); ev_hs[k] = ts; ev_hr[k] = tr; end
                    4: begin ev_ht[k] = tt; ev_hs[k] = ts; ev_hr[k] = oth_r; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] tt, ts, tr;
        for (int i = 0; i < 40; i++) begin
            tt = 8'($urandom_range(79, 0));
            ts = 8'($urandom_range(1, 0));
            tr = 8'($urandom_range(18, 1));
            for (int a = 0; a < 20; a++) begin
                gen_random(tt, ts, tr);
                model(tt, ts, tr);
                if (e_done >= 0) break;
            end
            run_req(tt, ts, tr);
        end
    endtask

    initial begin
        drive_zero();
        test_reset();
        test_basic_match();
        test_not_found();
        test_wrong_track();
        test_timeout();
        test_match_on_last_index();
        test_crc_and_busy_req();
        test_back_to_back();
        test_reset_mid_data();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
